// File: rtl/neuron_step_sched.sv
// Time-multiplexed scheduler for one shared neuron-update datapath.
// Sweeps all virtual neurons once per step_start and applies the spike, reset and refractory rules.
module neuron_step_sched #(
  parameter int                    N_NEUR = 8,
  parameter int                    V_W    = 16,
  parameter logic signed [V_W-1:0] V_TH   = 16'sd1024,
  parameter logic signed [V_W-1:0] V_RST  = -16'sd512,
  parameter int                    REFRAC = 4,
  parameter int                    REF_W  = 4,
  parameter int                    IDX_W  = $clog2(N_NEUR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic [IDX_W-1:0] cur_addr,
  input  logic [V_W-1:0]   cur_data,
  output logic             dp_req_valid,
  input  logic             dp_req_ready,
  output logic [V_W-1:0]   dp_v,
  output logic [V_W-1:0]   dp_i,
  input  logic             dp_rsp_valid,
  input  logic [V_W-1:0]   dp_rsp_v,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [V_W-1:0]   dbg_v
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_REQ, S_WAIT, S_WB, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [V_W-1:0]         v_mem   [N_NEUR];
  logic [REF_W-1:0]       ref_cnt [N_NEUR];
  logic signed [V_W-1:0]  rsp_q;
  logic                   last, refr, spike;

  assign last  = (idx == IDX_W'(N_NEUR - 1));
  assign refr  = (ref_cnt[idx] != '0);
  assign spike = (state == S_WB) && (rsp_q >= V_TH);
  assign dbg_v = v_mem[dbg_addr];

  // Handshake: a request transfers on the rising edge where dp_req_valid && dp_req_ready;
  // dp_v/dp_i stay frozen while valid is high; a response is taken only in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (step_start) state_nxt = S_FETCH;
      S_FETCH: if (refr) state_nxt = last ? S_DONE : S_FETCH;
               else      state_nxt = S_REQ;
      S_REQ:   if (dp_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (dp_rsp_valid) state_nxt = S_WB;
      S_WB:    state_nxt = last ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    step_done    = (state == S_DONE);
    dp_req_valid = (state == S_REQ);
    spike_valid  = spike;
    spike_idx    = spike ? idx : '0;
    cur_addr     = idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      dp_v  <= '0;
      dp_i  <= '0;
      rsp_q <= '0;
      for (int k = 0; k < N_NEUR; k++) begin
        v_mem[k]   <= V_RST;
        ref_cnt[k] <= '0;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (refr) begin
            ref_cnt[idx] <= ref_cnt[idx] - 1'b1;
            if (!last) idx <= idx + 1'b1;
          end else begin
            dp_v <= v_mem[idx];
            dp_i <= cur_data;
          end
        end
        S_WAIT: if (dp_rsp_valid) rsp_q <= dp_rsp_v;
        S_WB: begin
          if (spike) begin
            v_mem[idx]   <= V_RST;
            ref_cnt[idx] <= REF_W'(REFRAC);
          end else begin
            v_mem[idx] <= rsp_q;
          end
          if (!last) idx <= idx + 1'b1;
        end
        S_DONE:  idx <= '0;
        default: ;
      endcase
    end
  end

endmodule
